// File: rtl/jtsdram_prog_pkg.sv
// Shared types for the JTSDRAM pattern programmer/checker: sweep FSM states and mode codes.
package jtsdram_prog_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWr,
    StWrWait,
    StRd,
    StRdWait,
    StDone
  } prog_st_e;

  localparam logic [1:0] MODE_WR   = 2'd0;
  localparam logic [1:0] MODE_WRVF = 2'd1;
  localparam logic [1:0] MODE_VF   = 2'd2;

endpackage

// File: rtl/jtsdram_prog_cmp.sv
// Read-back comparator: saturating mismatch counter plus optional first-mismatch log
// (built only when JTSDRAM_ERRLOG_EN is defined, otherwise the log outputs read 0).
module jtsdram_prog_cmp #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [1:0]    ba_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] exp_i,
  input  logic [DW-1:0] got_i,
  output logic [15:0]   err_cnt_o,
  output logic [1:0]    err_ba_o,
  output logic [AW-1:0] err_addr_o,
  output logic [DW-1:0] err_exp_o,
  output logic [DW-1:0] err_got_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        mismatch;

  assign mismatch = vld_i && (exp_i != got_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (mismatch && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_cnt_o = cnt_q;

`ifdef JTSDRAM_ERRLOG_EN
  logic          logged_q, logged_d;
  logic [1:0]    ba_q, ba_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] exp_q, exp_d, got_q, got_d;

  // Only the first mismatch after a start is kept.
  always_comb begin
    logged_d = logged_q;
    ba_d     = ba_q;
    addr_d   = addr_q;
    exp_d    = exp_q;
    got_d    = got_q;
    if (clr_i) begin
      logged_d = 1'b0;
      ba_d     = '0;
      addr_d   = '0;
      exp_d    = '0;
      got_d    = '0;
    end else if (mismatch && !logged_q) begin
      logged_d = 1'b1;
      ba_d     = ba_i;
      addr_d   = addr_i;
      exp_d    = exp_i;
      got_d    = got_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      logged_q <= 1'b0;
      ba_q     <= '0;
      addr_q   <= '0;
      exp_q    <= '0;
      got_q    <= '0;
    end else begin
      logged_q <= logged_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      exp_q    <= exp_d;
      got_q    <= got_d;
    end
  end

  assign err_ba_o   = ba_q;
  assign err_addr_o = addr_q;
  assign err_exp_o  = exp_q;
  assign err_got_o  = got_q;
`else
  logic unused_log;
  assign unused_log = ^{ba_i, addr_i};

  assign err_ba_o   = '0;
  assign err_addr_o = '0;
  assign err_exp_o  = '0;
  assign err_got_o  = '0;
`endif

endmodule

// File: rtl/jtsdram_prog_chk.sv
// SDRAM pattern programmer/checker: sweeps all words of BANKS banks in write, write+verify or
// verify mode. First-mismatch capture ports are live only with JTSDRAM_ERRLOG_EN.
module jtsdram_prog_chk
  import jtsdram_prog_pkg::*;
#(
  parameter int unsigned AW    = 22,
  parameter int unsigned BANKS = 4,
  parameter int unsigned DW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                LVBL,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [15:0]         err_cnt,
  input  logic [BANKS*DW-1:0] ba_data,
  output logic [1:0]          next_ba,
  output logic [AW-1:0]       next_addr,
  input  logic [DW-1:0]       rd_data,
  output logic [AW-1:0]       prog_addr,
  output logic [1:0]          prog_ba,
  output logic [DW-1:0]       prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  output logic                prog_rd,
  input  logic                prog_ack,
  input  logic                prog_rdy,
  output logic                rfsh,
  output logic [1:0]          err_ba,
  output logic [AW-1:0]       err_addr,
  output logic [DW-1:0]       err_exp,
  output logic [DW-1:0]       err_got
);

  localparam int unsigned     CW      = AW + 2;
  localparam logic [1:0]      LastBa  = 2'(BANKS - 1);
  localparam logic [CW-1:0]   LastCnt = {LastBa, {AW{1'b1}}};

  prog_st_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] exp_q, exp_d, data_q, data_d, pat_sel;
  logic [1:0]    mode_q, mode_d, ba_q, ba_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          verify_q, verify_d, we_q, we_d, rd_q, rd_d, done_q, done_d;
  logic          frame_q, lvbl_q;
  logic          cmp_vld, word_end;
  logic [1:0]    cnt_ba;
  logic [AW-1:0] cnt_addr;

  assign cnt_ba   = cnt_q[CW-1 -: 2];
  assign cnt_addr = cnt_q[AW-1:0];

  always_comb begin
    pat_sel = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (cnt_ba == 2'(b)) pat_sel = ba_data[b*DW +: DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exp_d    = exp_q;
    data_d   = data_q;
    mode_d   = mode_q;
    ba_d     = ba_q;
    addr_d   = addr_q;
    verify_d = verify_q;
    we_d     = we_q;
    rd_d     = rd_q;
    done_d   = done_q;
    cmp_vld  = 1'b0;
    word_end = 1'b0;
    if (start) begin
      // Restart wins over everything; any in-flight access is simply dropped.
      mode_d   = (mode == 2'd3) ? MODE_WR : mode;
      cnt_d    = '0;
      verify_d = 1'b0;
      we_d     = 1'b0;
      rd_d     = 1'b0;
      done_d   = 1'b0;
      state_d  = StSetup;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
        end
        StSetup: begin
          exp_d   = pat_sel;
          state_d = ((mode_q == MODE_VF) || verify_q) ? StRd : StWr;
        end
        StWr: begin
          we_d    = 1'b1;
          ba_d    = cnt_ba;
          addr_d  = cnt_addr;
          data_d  = exp_q;
          state_d = StWrWait;
        end
        StWrWait: begin
          if (prog_ack || prog_rdy) we_d = 1'b0;
          word_end = prog_rdy;
        end
        StRd: begin
          rd_d    = 1'b1;
          ba_d    = cnt_ba;
          addr_d  = cnt_addr;
          state_d = StRdWait;
        end
        StRdWait: begin
          if (prog_ack || prog_rdy) rd_d = 1'b0;
          word_end = prog_rdy;
          cmp_vld  = prog_rdy;
        end
        default: state_d = StIdle;
      endcase
      if (word_end) begin
        if (cnt_q != LastCnt) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = StSetup;
        end else if ((mode_q == MODE_WRVF) && !verify_q) begin
          cnt_d    = '0;
          verify_d = 1'b1;
          state_d  = StSetup;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      exp_q    <= '0;
      data_q   <= '0;
      mode_q   <= MODE_WR;
      ba_q     <= '0;
      addr_q   <= '0;
      verify_q <= 1'b0;
      we_q     <= 1'b0;
      rd_q     <= 1'b0;
      done_q   <= 1'b0;
      frame_q  <= 1'b0;
      lvbl_q   <= LVBL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exp_q    <= exp_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      ba_q     <= ba_d;
      addr_q   <= addr_d;
      verify_q <= verify_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      done_q   <= done_d;
      lvbl_q   <= LVBL;
      if (LVBL && !lvbl_q) frame_q <= ~frame_q;
    end
  end

  jtsdram_prog_cmp #(
    .AW (AW),
    .DW (DW)
  ) u_cmp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (start),
    .vld_i      (cmp_vld),
    .ba_i       (cnt_ba),
    .addr_i     (cnt_addr),
    .exp_i      (exp_q),
    .got_i      (rd_data),
    .err_cnt_o  (err_cnt),
    .err_ba_o   (err_ba),
    .err_addr_o (err_addr),
    .err_exp_o  (err_exp),
    .err_got_o  (err_got)
  );

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = done_q;
  assign pass      = done_q && (err_cnt == 16'd0);
  assign next_ba   = cnt_ba;
  assign next_addr = cnt_addr;
  assign prog_addr = addr_q;
  assign prog_ba   = ba_q;
  assign prog_data = data_q;
  assign prog_mask = busy ? 2'b00 : 2'b11;
  assign prog_we   = we_q;
  assign prog_rd   = rd_q;
  assign rfsh      = frame_q & ~LVBL;

endmodule

// File: tb/tb_jtsdram_prog_chk.sv
// Directed/randomized bench for jtsdram_prog_chk with a behavioural SDRAM controller and sweep model.
module tb_jtsdram_prog_chk;

  localparam int AW    = 4;
  localparam int BANKS = 2;
  localparam int DW    = 16;
  localparam int NW    = BANKS << AW;
  localparam logic [15:0] CMASK = 16'h00A5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          LVBL = 1'b0;
  logic          busy, done, pass, prog_we, prog_rd, rfsh;
  logic [15:0]   err_cnt;
  logic [BANKS*DW-1:0] ba_data;
  logic [1:0]    next_ba, prog_ba, prog_mask, err_ba;
  logic [AW-1:0] next_addr, prog_addr, err_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] prog_data, err_exp, err_got;
  logic          prog_ack = 1'b0;
  logic          prog_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [15:0] seed = 16'h0;
  int          lat_min = 3, lat_max = 3, corrupt_w = -1;
  bit          split = 1'b0;

  logic [15:0] mem [64];
  logic [15:0] model_mem [64];
  logic [22:0] txn_log [$];
  logic [22:0] exp_log [$];
  int          exp_err;
  bit          exp_rd_seen, exp_we_seen, rd_seen, we_seen;
  logic [5:0]  fe_w;
  logic [15:0] fe_exp, fe_got;
  bit          fe_valid;

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] s, input logic [1:0] ba,
                                      input logic [3:0] a);
    return s ^ {10'd0, ba, a};
  endfunction

  assign ba_data = {pat(seed, 2'd1, next_addr), pat(seed, 2'd0, next_addr)};

  jtsdram_prog_chk #(
    .AW    (AW),
    .BANKS (BANKS),
    .DW    (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .LVBL      (LVBL),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .ba_data   (ba_data),
    .next_ba   (next_ba),
    .next_addr (next_addr),
    .rd_data   (rd_data),
    .prog_addr (prog_addr),
    .prog_ba   (prog_ba),
    .prog_data (prog_data),
    .prog_mask (prog_mask),
    .prog_we   (prog_we),
    .prog_rd   (prog_rd),
    .prog_ack  (prog_ack),
    .prog_rdy  (prog_rdy),
    .rfsh      (rfsh),
    .err_ba    (err_ba),
    .err_addr  (err_addr),
    .err_exp   (err_exp),
    .err_got   (err_got)
  );

  // Behavioural controller: one outstanding access, response after lat cycles.
  bit          pend = 1'b0, pwr = 1'b0;
  int          lat = 0;
  logic [5:0]  pw = '0;
  logic [15:0] pdat = '0, rdv = '0;
  always @(negedge clk) begin
    prog_ack = 1'b0;
    prog_rdy = 1'b0;
    if (prog_rd) rd_seen = 1'b1;
    if (prog_we) we_seen = 1'b1;
    if (!rst_n || start) begin
      pend = 1'b0;
    end else begin
      if (!pend && (prog_we || prog_rd)) begin
        pend = 1'b1;
        pwr  = prog_we;
        pw   = {prog_ba, prog_addr};
        pdat = prog_data;
        lat  = $urandom_range(lat_max, lat_min);
        if (split) prog_ack = 1'b1;
      end
      if (pend) begin
        if (lat == 0) begin
          pend = 1'b0;
          prog_ack = 1'b1;
          prog_rdy = 1'b1;
          if (pwr) begin
            mem[pw] = pdat;
            rdv = pdat;
          end else begin
            rdv = mem[pw] ^ ((int'(pw) == corrupt_w) ? CMASK : 16'h0);
            rd_data = rdv;
          end
          txn_log.push_back({pwr, pw, rdv});
        end else begin
          lat--;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected transaction list, error count and first mismatch straight from the sweep rules.
  task automatic build_expect(input logic [1:0] m);
    logic [15:0] p, ret;
    bit do_wr, do_rd;
    do_wr = (m != 2'd2);
    do_rd = (m == 2'd1) || (m == 2'd2);
    exp_log.delete();
    exp_err = 0;
    fe_valid = 1'b0;
    fe_w = '0;
    fe_exp = '0;
    fe_got = '0;
    if (do_wr) begin
      for (int w = 0; w < NW; w++) begin
        p = pat(seed, 2'(w >> AW), 4'(w));
        model_mem[w] = p;
        exp_log.push_back({1'b1, 6'(w), p});
      end
    end
    if (do_rd) begin
      for (int w = 0; w < NW; w++) begin
        p = pat(seed, 2'(w >> AW), 4'(w));
        ret = model_mem[w] ^ ((w == corrupt_w) ? CMASK : 16'h0);
        exp_log.push_back({1'b0, 6'(w), ret});
        if (ret != p) begin
          exp_err++;
          if (!fe_valid) begin
            fe_valid = 1'b1;
            fe_w = 6'(w);
            fe_exp = p;
            fe_got = ret;
          end
        end
      end
    end
    exp_rd_seen = do_rd;
    exp_we_seen = do_wr;
  endtask

  task automatic do_start(input logic [1:0] m);
    build_expect(m);
    txn_log.delete();
    mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    check("start_busy", busy, 1);
    check("start_done_clr", done, 0);
    check("start_err_clr", err_cnt, 0);
    check("start_req_clr", {prog_we, prog_rd}, 0);
    check("start_cnt_clr", {next_ba, next_addr}, 0);
    check("sweep_mask", prog_mask, 0);
    rd_seen = 1'b0;
    we_seen = 1'b0;
    @(posedge clk); #1;
    check("lat1_noreq", {prog_we, prog_rd}, 0);
    @(posedge clk); #1;
    check("lat2_req", {prog_we, prog_rd}, (m == 2'd2) ? 2'b01 : 2'b10);
  endtask

  task automatic finish_sweep(input string tag);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("%s_done", tag), done, 1);
    check($sformatf("%s_busy", tag), busy, 0);
    check($sformatf("%s_pass", tag), pass, (exp_err == 0));
    check($sformatf("%s_errcnt", tag), err_cnt, exp_err);
    check($sformatf("%s_mask", tag), prog_mask, 2'b11);
    check($sformatf("%s_ntxn", tag), txn_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < txn_log.size(); i++) begin
      check($sformatf("%s_txn%0d", tag, i), txn_log[i], exp_log[i]);
    end
    check($sformatf("%s_rdseen", tag), rd_seen, exp_rd_seen);
    check($sformatf("%s_weseen", tag), we_seen, exp_we_seen);
`ifdef JTSDRAM_ERRLOG_EN
    check($sformatf("%s_errlog", tag), {err_ba, err_addr, err_exp, err_got},
          {fe_w[5:4], fe_w[3:0], fe_exp, fe_got});
`else
    check($sformatf("%s_errlog", tag), {err_ba, err_addr, err_exp, err_got}, 0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit frame;
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {busy, done, pass, prog_we, prog_rd, rfsh}, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_mask", prog_mask, 2'b11);
    check("rst_next", {next_ba, next_addr}, 0);
    check("rst_prog", {prog_ba, prog_addr, prog_data}, 0);
    rst_n = 1'b1;
    LVBL = 1'b1;
    @(posedge clk); #1;

    // Mode 0, pattern {ba,addr}, 3-cycle controller.
    seed = 16'h0; lat_min = 3; lat_max = 3; split = 1'b0; corrupt_w = -1;
    do_start(2'd0);
    finish_sweep("wr");

    do_start(2'd1);
    finish_sweep("wrvf");

    // Verify only, one corrupted word at bank 1 addr 5.
    lat_min = 0; lat_max = 4; split = 1'($urandom_range(1, 0)); corrupt_w = 16 + 5;
    do_start(2'd2);
    finish_sweep("vf_corrupt");

    // ack and rdy in the same cycle as the request.
    seed = 16'($urandom); lat_min = 0; lat_max = 0; split = 1'b0; corrupt_w = -1;
    do_start(2'd1);
    finish_sweep("zero_lat");

    // Mode 3 acts as write only.
    seed = 16'($urandom); lat_min = 0; lat_max = 2; split = 1'b1;
    do_start(2'd3);
    finish_sweep("mode3");

    // Verify against a different pattern: every word mismatches.
    seed = seed ^ 16'($urandom_range(65535, 1)); lat_min = 1; lat_max = 3; split = 1'b0;
    do_start(2'd2);
    finish_sweep("vf_allbad");

    // Restart at word 7 of a write+verify sweep.
    seed = 16'($urandom); lat_min = 0; lat_max = 3; split = 1'($urandom_range(1, 0));
    do_start(2'd1);
    n = 0;
    while (!(next_ba == 2'd0 && next_addr == 4'd7) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart_reach_w7", {next_ba, next_addr}, 6'd7);
    do_start(2'd1);
    finish_sweep("restart");

    // Reset in the middle of a sweep.
    seed = 16'($urandom); lat_min = 1; lat_max = 2;
    do_start(2'd1);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    LVBL = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_flags", {busy, done, pass, prog_we, prog_rd, rfsh}, 0);
    check("midrst_errcnt", err_cnt, 0);
    check("midrst_mask", prog_mask, 2'b11);
    check("midrst_next", {next_ba, next_addr}, 0);
    check("midrst_prog", {prog_ba, prog_addr, prog_data}, 0);
    check("midrst_errlog", {err_ba, err_addr, err_exp, err_got}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_idle", {busy, done, prog_we, prog_rd}, 0);

    // Refresh: frame toggles on each LVBL rise, rfsh = frame & ~LVBL.
    frame = 1'b0;
    check("rfsh_init", rfsh, 0);
    for (int k = 0; k < 3; k++) begin
      LVBL = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      frame = ~frame;
      check($sformatf("rfsh_hi%0d", k), rfsh, 0);
      LVBL = 1'b0;
      @(posedge clk); #1;
      check($sformatf("rfsh_lo%0d", k), rfsh, frame);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rfsh_rst", rfsh, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
